// File: rtl/mem_ctrl_burst.sv
// Byte-serial RAM controller arbitrating LSB loads/stores and icache line fills on one 8-bit port.
// MEMCTRL_PREEMPT_EN: let a pending LSB request suspend a fill at a word boundary.
module mem_ctrl_burst #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LINE_WORDS   = 4,
  parameter int LSB_ID_WIDTH = 4,
  localparam int IDX_W       = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_WIDTH-1:0]   mem_aout,
  output logic                    mem_rw,
  input  logic                    io_buffer_full,
  input  logic                    lsb_req,
  input  logic                    lsb_we,
  input  logic [ADDR_WIDTH-1:0]   lsb_addr,
  input  logic [1:0]              lsb_size,
  input  logic                    lsb_signed,
  input  logic [31:0]             lsb_wdata,
  input  logic [LSB_ID_WIDTH-1:0] lsb_tag,
  output logic                    lsb_done,
  output logic [31:0]             lsb_rdata,
  output logic [LSB_ID_WIDTH-1:0] lsb_done_tag,
  input  logic                    ic_req,
  input  logic [ADDR_WIDTH-1:0]   ic_addr,
  input  logic                    flush,
  output logic                    ic_word_valid,
  output logic [31:0]             ic_word,
  output logic [IDX_W-1:0]        ic_word_idx,
  output logic                    ic_done,
  output logic                    busy
);

  localparam int LINE_BYTES = 4 * LINE_WORDS;
  localparam int PTR_W      = $clog2(LINE_BYTES) + 1;
  typedef logic [PTR_W-1:0] ptr_t;

  typedef enum logic [2:0] {IDLE, LSB_RD, LSB_WR, IC_RD, DRAIN} state_t;

  state_t                  state, next_state;
  logic [ADDR_WIDTH-1:0]   base_addr, cur_addr;
  ptr_t                    cnt, ip, cp, eff_ip;
  logic                    inflight, rdy_q;
  logic [1:0]              size_q;
  logic                    signed_q;
  logic [31:0]             wdata_q, asm_q, asm_next;
  logic [LSB_ID_WIDTH-1:0] tag_q;
  logic                    resume, rd_state, addr_live, io_stall, ic_flush;
  logic                    issue, capture, last_cap, last_issue, word_end, idle_free;
`ifdef MEMCTRL_PREEMPT_EN
  logic                    susp, preempt;
  ptr_t                    susp_ptr;
`endif

  function automatic ptr_t lsb_bytes(input logic [1:0] sz);
    case (sz)
      2'd0:    return ptr_t'(1);
      2'd1:    return ptr_t'(2);
      default: return ptr_t'(4);
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] w, input logic [1:0] sz,
                                              input logic sgn);
    case (sz)
      2'd0:    return {{24{sgn & w[7]}}, w[7:0]};
      2'd1:    return {{16{sgn & w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  // After an rdy_in stall, issue restarts at the first byte not yet captured.
  always_comb begin
    resume     = rdy_in && !rdy_q;
    eff_ip     = resume ? cp : ip;
    rd_state   = (state == LSB_RD) || (state == IC_RD) || (state == DRAIN);
    addr_live  = (rd_state || (state == LSB_WR)) && (eff_ip < cnt);
    cur_addr   = base_addr + ADDR_WIDTH'(eff_ip);
    io_stall   = (state == LSB_WR) && (cur_addr[17:16] == 2'b11) && io_buffer_full;
    ic_flush   = flush && ((state == IC_RD) || (state == DRAIN));
    issue      = rdy_in && addr_live && !io_stall && !ic_flush;
    capture    = rdy_in && !resume && inflight && rd_state && !ic_flush;
    last_cap   = capture && (cp == cnt - ptr_t'(1));
    last_issue = issue && (eff_ip == cnt - ptr_t'(1));
    word_end   = capture && (cp[1:0] == 2'b11);
    idle_free  = !lsb_done && !ic_done;
    asm_next   = asm_q;
    asm_next[{cp[1:0], 3'b000} +: 8] = mem_din;
  end

`ifdef MEMCTRL_PREEMPT_EN
  assign preempt = (state == IC_RD) && issue && (eff_ip[1:0] == 2'b11) &&
                   (eff_ip < ptr_t'(LINE_BYTES - 4)) && lsb_req;
`endif

  always_ff @(posedge clk) begin
    if (rst_in) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (rdy_in) begin
      case (state)
        IDLE: begin
          if (idle_free) begin
            if (lsb_req)     next_state = lsb_we ? LSB_WR : LSB_RD;
            else if (ic_req) next_state = IC_RD;
          end
        end
        LSB_RD: if (last_cap)   next_state = IDLE;
        LSB_WR: if (last_issue) next_state = IDLE;
        IC_RD: begin
          if (ic_flush || last_cap) next_state = IDLE;
`ifdef MEMCTRL_PREEMPT_EN
          else if (preempt)         next_state = DRAIN;
`endif
        end
        DRAIN:  if (ic_flush || last_cap) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state != IDLE);
    mem_aout = addr_live ? cur_addr : '0;
    mem_rw   = issue && (state == LSB_WR);
    mem_dout = (addr_live && (state == LSB_WR)) ? wdata_q[{eff_ip[1:0], 3'b000} +: 8] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      base_addr     <= '0;
      cnt           <= '0;
      ip            <= '0;
      cp            <= '0;
      inflight      <= 1'b0;
      rdy_q         <= 1'b1;
      size_q        <= '0;
      signed_q      <= 1'b0;
      wdata_q       <= '0;
      tag_q         <= '0;
      asm_q         <= '0;
      lsb_done      <= 1'b0;
      lsb_rdata     <= '0;
      lsb_done_tag  <= '0;
      ic_word_valid <= 1'b0;
      ic_word       <= '0;
      ic_word_idx   <= '0;
      ic_done       <= 1'b0;
`ifdef MEMCTRL_PREEMPT_EN
      susp          <= 1'b0;
      susp_ptr      <= '0;
`endif
    end else begin
      rdy_q         <= rdy_in;
      lsb_done      <= 1'b0;
      lsb_rdata     <= '0;
      lsb_done_tag  <= '0;
      ic_word_valid <= 1'b0;
      ic_word       <= '0;
      ic_word_idx   <= '0;
      ic_done       <= 1'b0;
      if (rdy_in) begin
        if (state == IDLE) begin
          inflight <= 1'b0;
          if (idle_free && (lsb_req || ic_req)) begin
            asm_q <= '0;
            ip    <= '0;
            cp    <= '0;
            if (lsb_req) begin
              base_addr <= lsb_addr;
              cnt       <= lsb_bytes(lsb_size);
              size_q    <= lsb_size;
              signed_q  <= lsb_signed;
              wdata_q   <= lsb_wdata;
              tag_q     <= lsb_tag;
            end else begin
              base_addr <= ic_addr;
              cnt       <= ptr_t'(LINE_BYTES);
`ifdef MEMCTRL_PREEMPT_EN
              if (susp && !flush) begin
                ip <= susp_ptr;
                cp <= susp_ptr;
              end
              susp <= 1'b0;
`endif
            end
          end
        end else begin
          ip       <= issue ? eff_ip + ptr_t'(1) : eff_ip;
          inflight <= issue && rd_state;
          if (capture) begin
            cp    <= cp + ptr_t'(1);
            asm_q <= asm_next;
          end
          // Stores have nothing to capture: a byte counts as done once written.
          if ((state == LSB_WR) && issue) cp <= eff_ip + ptr_t'(1);
          if ((state == LSB_RD) && last_cap) begin
            lsb_done     <= 1'b1;
            lsb_rdata    <= extend_load(asm_next, size_q, signed_q);
            lsb_done_tag <= tag_q;
          end
          if ((state == LSB_WR) && last_issue) begin
            lsb_done     <= 1'b1;
            lsb_done_tag <= tag_q;
          end
          if (word_end && ((state == IC_RD) || (state == DRAIN))) begin
            ic_word_valid <= 1'b1;
            ic_word       <= asm_next;
            ic_word_idx   <= cp[IDX_W+1:2];
            ic_done       <= (state == IC_RD) && last_cap;
          end
`ifdef MEMCTRL_PREEMPT_EN
          // DRAIN collects only the word already on the wire, then hands over.
          if (preempt) begin
            cnt      <= eff_ip + ptr_t'(1);
            susp_ptr <= eff_ip + ptr_t'(1);
          end
          if ((state == DRAIN) && last_cap) susp <= 1'b1;
`endif
        end
`ifdef MEMCTRL_PREEMPT_EN
        if (flush && susp) susp <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl_burst.sv
// Bench for mem_ctrl_burst: directed scenarios plus randomized traffic against a byte-level memory model.
module tb_mem_ctrl_burst;
  logic        clk = 1'b0;
  logic        rst_in, rdy_in, mem_rw, io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_aout, lsb_addr, lsb_wdata, lsb_rdata, ic_addr, ic_word;
  logic        lsb_req, lsb_we, lsb_signed, lsb_done, ic_req, flush, ic_word_valid, ic_done, busy;
  logic [1:0]  lsb_size, ic_word_idx;
  logic [3:0]  lsb_tag, lsb_done_tag;

  int checks = 0;
  int errors = 0;

  mem_ctrl_burst dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_aout(mem_aout), .mem_rw(mem_rw), .io_buffer_full(io_buffer_full),
    .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_addr(lsb_addr), .lsb_size(lsb_size),
    .lsb_signed(lsb_signed), .lsb_wdata(lsb_wdata), .lsb_tag(lsb_tag), .lsb_done(lsb_done),
    .lsb_rdata(lsb_rdata), .lsb_done_tag(lsb_done_tag), .ic_req(ic_req), .ic_addr(ic_addr),
    .flush(flush), .ic_word_valid(ic_word_valid), .ic_word(ic_word), .ic_word_idx(ic_word_idx),
    .ic_done(ic_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Unwritten locations hold a fixed address-derived pattern; RAM aliases every 4 KiB.
  function automatic logic [7:0] fill_byte(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h3C;
  endfunction

  bit [7:0] ram [0:4095];
  bit       ram_wr [0:4095];
  always @(posedge clk) begin
    mem_din <= ram_wr[mem_aout[11:0]] ? ram[mem_aout[11:0]] : fill_byte(mem_aout[11:0]);
    if (mem_rw) begin
      ram[mem_aout[11:0]]    <= mem_dout;
      ram_wr[mem_aout[11:0]] <= 1'b1;
    end
  end

  bit [7:0] ref_mem [0:4095];
  bit       ref_wr  [0:4095];

  function automatic logic [7:0] mb(input logic [31:0] a);
    return ref_wr[a[11:0]] ? ref_mem[a[11:0]] : fill_byte(a[11:0]);
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] sz, input bit sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = mb(a);
    h = {mb(a + 1), mb(a)};
    if (sz == 2'd0) return sgn ? 32'($signed(b)) : {24'h0, b};
    if (sz == 2'd1) return sgn ? 32'($signed(h)) : {16'h0, h};
    return {mb(a + 3), mb(a + 2), h};
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    for (int i = 0; i < nbytes(sz); i++) begin
      ref_mem[(a + i) & 32'hFFF] = wd[8*i +: 8];
      ref_wr[(a + i) & 32'hFFF]  = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] wr_addr [$];
  logic [7:0]  wr_data [$];
  int          wr_cyc  [$];
  int          rw_stalled;
  logic [31:0] w_data [0:15];
  int          w_idx  [0:15];
  int          w_cyc  [0:15];

  // Cycle 0 is the cycle in which lsb_req is first sampled; inputs are set just after each negedge.
  task automatic lsb_op(input bit we, input logic [31:0] a, input logic [1:0] sz, input bit sgn,
                        input logic [31:0] wd, input logic [3:0] tag, input logic [31:0] io_mask,
                        input logic [31:0] rdy_mask, output int dcyc, output logic [31:0] rd,
                        output logic [3:0] dtag);
    @(negedge clk);
    lsb_req = 1'b1; lsb_we = we; lsb_addr = a; lsb_size = sz; lsb_signed = sgn;
    lsb_wdata = wd; lsb_tag = tag; io_buffer_full = 1'b0; rdy_in = 1'b1;
    dcyc = -1; rd = 'x; dtag = 'x; rw_stalled = 0;
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    for (int c = 1; c < 60 && dcyc < 0; c++) begin
      @(negedge clk);
      io_buffer_full = (c < 32) ? io_mask[c] : 1'b0;
      rdy_in         = (c < 32) ? !rdy_mask[c] : 1'b1;
      #1;
      if (mem_rw) begin
        wr_addr.push_back(mem_aout); wr_data.push_back(mem_dout); wr_cyc.push_back(c);
        if (!rdy_in) rw_stalled++;
      end
      if (lsb_done) begin
        dcyc = c; rd = lsb_rdata; dtag = lsb_done_tag; lsb_req = 1'b0;
      end
    end
    lsb_req = 1'b0; io_buffer_full = 1'b0; rdy_in = 1'b1;
  endtask

  task automatic ic_op(input logic [31:0] a, input int flush_c, output int nw, output int done_c,
                       output int busy_at);
    @(negedge clk);
    ic_req = 1'b1; ic_addr = a;
    nw = 0; done_c = -1; busy_at = -1;
    for (int c = 1; c < 100 && done_c < 0 && !(flush_c > 0 && c > flush_c + 4); c++) begin
      @(negedge clk);
      flush = (c == flush_c);
      if (c == flush_c) ic_req = 1'b0;
      #1;
      if (ic_word_valid && nw < 16) begin
        w_data[nw] = ic_word; w_idx[nw] = int'(ic_word_idx); w_cyc[nw] = c; nw++;
      end
      if (ic_done) begin done_c = c; ic_req = 1'b0; end
      if (c == flush_c + 1) busy_at = int'(busy);
    end
    flush = 1'b0; ic_req = 1'b0;
  endtask

  function automatic logic [31:0] line_word(input logic [31:0] a, input int w);
    return {mb(a + 4*w + 3), mb(a + 4*w + 2), mb(a + 4*w + 1), mb(a + 4*w)};
  endfunction

  initial begin
    int          dc, nw, dn, ba, n, k, c, issued;
    logic [31:0] rd, a, wd, iom;
    logic [3:0]  dt, tg;
    logic [1:0]  sz;
    bit          sg;
    logic [31:0] ew;

    rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0; lsb_req = 1'b0; lsb_we = 1'b0;
    lsb_addr = '0; lsb_size = '0; lsb_signed = 1'b0; lsb_wdata = '0; lsb_tag = '0;
    ic_req = 1'b0; ic_addr = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_mem_rw", {31'b0, mem_rw}, 0);
    check("rst_mem_aout", mem_aout, 0);
    check("rst_mem_dout", {24'b0, mem_dout}, 0);
    check("rst_lsb_done", {31'b0, lsb_done}, 0);
    check("rst_lsb_rdata", lsb_rdata, 0);
    check("rst_ic_valid", {31'b0, ic_word_valid}, 0);
    check("rst_ic_done", {31'b0, ic_done}, 0);
    rst_in = 1'b0;

    // Byte store 0x80, then signed and unsigned byte loads from the same address.
    lsb_op(1, 32'h100, 2'd0, 0, 32'h80, 4'h1, 0, 0, dc, rd, dt);
    ref_store(32'h100, 2'd0, 32'h80);
    check("bstore_lat", dc, 2);
    lsb_op(0, 32'h100, 2'd0, 1, 0, 4'h5, 0, 0, dc, rd, dt);
    check("sbyte_lat", dc, 3);
    check("sbyte_data", rd, 32'hFFFF_FF80);
    check("sbyte_tag", {28'b0, dt}, 5);
    lsb_op(0, 32'h100, 2'd0, 0, 0, 4'h6, 0, 0, dc, rd, dt);
    check("ubyte_data", rd, 32'h0000_0080);

    // Word store: one byte per cycle, little-endian.
    lsb_op(1, 32'h200, 2'd2, 0, 32'hDEAD_BEEF, 4'h2, 0, 0, dc, rd, dt);
    ref_store(32'h200, 2'd2, 32'hDEAD_BEEF);
    check("wstore_lat", dc, 5);
    check("wstore_nwr", wr_addr.size(), 4);
    ew = 32'hDEAD_BEEF;
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      check("wstore_addr", wr_addr[i], 32'h200 + i);
      check("wstore_data", {24'b0, wr_data[i]}, {24'b0, ew[8*i +: 8]});
      check("wstore_cyc", wr_cyc[i], i + 1);
    end

    // IO store blocked by a full buffer in cycles 1..3.
    lsb_op(1, 32'h30000, 2'd0, 0, 32'h5A, 4'h3, 32'h0000_000E, 0, dc, rd, dt);
    ref_store(32'h30000, 2'd0, 32'h5A);
    check("io_lat", dc, 5);
    check("io_nwr", wr_addr.size(), 1);
    if (wr_cyc.size() > 0) check("io_wr_cyc", wr_cyc[0], 4);

    // Fill flushed in cycle 8.
    ic_op(32'h40, 8, nw, dn, ba);
    check("flush_nwords", nw, 1);
    check("flush_w0_cyc", w_cyc[0], 6);
    check("flush_w0_idx", w_idx[0], 0);
    check("flush_w0_data", w_data[0], line_word(32'h40, 0));
    check("flush_no_done", dn, -1);
    check("flush_busy9", ba, 0);

    // Full fill.
    ic_op(32'h80, 0, nw, dn, ba);
    check("fill_nwords", nw, 4);
    check("fill_done_cyc", dn, 18);
    for (int w = 0; w < 4 && w < nw; w++) begin
      check("fill_cyc", w_cyc[w], 4*w + 6);
      check("fill_idx", w_idx[w], w);
      check("fill_data", w_data[w], line_word(32'h80, w));
    end

    // rdy_in low during cycles 3 and 4 of a word load.
    lsb_op(0, 32'h200, 2'd2, 0, 0, 4'h9, 0, 32'h0000_0018, dc, rd, dt);
    check("rdy_ld_data", rd, 32'hDEAD_BEEF);
    check("rdy_ld_late", {31'b0, dc >= 8 && dc <= 12}, 1);

    // rdy_in low in the middle of a store: no write may occur while stalled.
    lsb_op(1, 32'h300, 2'd2, 0, 32'h1234_5678, 4'h4, 0, 32'h0000_000C, dc, rd, dt);
    ref_store(32'h300, 2'd2, 32'h1234_5678);
    check("rdy_st_norw", rw_stalled, 0);
    check("rdy_st_done", {31'b0, dc > 5}, 1);
    lsb_op(0, 32'h300, 2'd2, 0, 0, 4'h7, 0, 0, dc, rd, dt);
    check("rdy_st_readback", rd, 32'h1234_5678);

`ifdef MEMCTRL_PREEMPT_EN
    begin
      int ld_c, icd;
      logic [31:0] ld_d;
      @(negedge clk);
      ic_req = 1'b1; ic_addr = 32'h80;
      lsb_we = 1'b0; lsb_addr = 32'h200; lsb_size = 2'd2; lsb_signed = 1'b0; lsb_tag = 4'hA;
      nw = 0; ld_c = -1; icd = -1; ld_d = '0;
      for (int cc = 1; cc < 100 && icd < 0; cc++) begin
        @(negedge clk);
        if (cc == 2) lsb_req = 1'b1;
        #1;
        if (ic_word_valid && nw < 16) begin
          w_data[nw] = ic_word; w_idx[nw] = int'(ic_word_idx); w_cyc[nw] = cc; nw++;
        end
        if (lsb_done) begin ld_c = cc; ld_d = lsb_rdata; lsb_req = 1'b0; end
        if (ic_done) begin icd = cc; ic_req = 1'b0; end
      end
      ic_req = 1'b0; lsb_req = 1'b0;
      check("pre_w0_cyc", w_cyc[0], 6);
      check("pre_ld_cyc", ld_c, 12);
      check("pre_ld_data", ld_d, 32'hDEAD_BEEF);
      check("pre_ic_done", {31'b0, icd > 0}, 1);
      check("pre_nwords", nw, 4);
      for (int w = 0; w < 4 && w < nw; w++) begin
        check("pre_idx", w_idx[w], w);
        check("pre_data", w_data[w], line_word(32'h80, w));
      end
    end
`endif

    // Randomized traffic.
    for (k = 0; k < 40; k++) begin
      case ($urandom_range(0, 2))
        0: begin
          a  = 32'h400 + $urandom_range(0, 32'hBF0);
          sz = 2'($urandom_range(0, 3));
          sg = 1'($urandom_range(0, 1));
          tg = 4'($urandom_range(0, 15));
          lsb_op(0, a, sz, sg, 0, tg, 0, 0, dc, rd, dt);
          check("rnd_ld_lat", dc, nbytes(sz) + 2);
          check("rnd_ld_data", rd, exp_load(a, sz, sg));
          check("rnd_ld_tag", {28'b0, dt}, {28'b0, tg});
        end
        1: begin
          a  = 32'h400 + $urandom_range(0, 32'hBF0);
          if ($urandom_range(0, 1) == 1) a = a | 32'h30000;
          sz  = 2'($urandom_range(0, 3));
          wd  = $urandom;
          iom = $urandom & 32'h0000_003E;
          n   = nbytes(sz);
          issued = 0;
          c = 1;
          while (issued < n && c < 32) begin
            if (!(iom[c] && (((a + issued) >> 16) & 3) == 3)) issued++;
            c++;
          end
          lsb_op(1, a, sz, 0, wd, 4'h0, iom, 0, dc, rd, dt);
          check("rnd_st_lat", dc, c);
          check("rnd_st_nwr", wr_addr.size(), n);
          for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            check("rnd_st_addr", wr_addr[i], a + i);
            check("rnd_st_data", {24'b0, wr_data[i]}, {24'b0, wd[8*i +: 8]});
          end
          ref_store(a, sz, wd);
        end
        default: begin
          a = {20'b0, 8'($urandom_range(16, 255)), 4'b0};
          ic_op(a, 0, nw, dn, ba);
          check("rnd_ic_nw", nw, 4);
          check("rnd_ic_done", dn, 18);
          for (int w = 0; w < 4 && w < nw; w++) begin
            check("rnd_ic_cyc", w_cyc[w], 4*w + 6);
            check("rnd_ic_data", w_data[w], line_word(a, w));
          end
        end
      endcase
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
